fir_stream_ctrl: RTL and testbench

Sequencing controller for the 32-tap FIR compensation filter. It accepts decimated microphone samples over a valid/ready stream and issues them to the FIR one at a time. It captures each filter result a fixed number of cycles after issue, because the FIR's y_out_valid stays high once primed and cannot mark individual results. Results go into a small output FIFO feeding the downstream valid/ready stream. The block also provides bypass, and a zero-flush of the FIR delay line when the stream is disabled.

---
 rtl/fir_stream_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Sequencing controller for the 32-tap FIR: issues one sample at a time, captures the
// result a fixed latency later, buffers results in a small FIFO, and zero-flushes on disable.
module fir_stream_ctrl #(
  parameter int DW      = 16,
  parameter int TAPS    = 32,
  parameter int FIR_LAT = 5,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          bypass,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] fir_x,
  output logic          fir_x_valid,
  input  logic [DW-1:0] fir_y,
  input  logic          fir_y_valid,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic [7:0]    discard_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + FIR_LAT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fir_x_q, fir_x_d;
  logic          fir_x_valid_q, fir_x_valid_d;
  logic          flush_pending_q, flush_pending_d;
  logic          enable_q, enable_d;
  logic [7:0]    discard_q, discard_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          fifo_full_s;
  logic          s_ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] push_data_s;
  logic          enable_fall_s;

  assign fifo_full_s   = (count_q == (AW+1)'(DEPTH));
  assign s_ready_s     = ~reset & (state_q == S_IDLE) & enable & ~flush_pending_q & ~fifo_full_s;
  assign accept_s      = s_valid & s_ready_s;
  assign pop_s         = (count_q != '0) & m_ready;
  assign enable_fall_s = enable_q & ~enable;

  // Sequencer: issue, fixed-latency capture, and the flush/drain sequence.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fir_x_d         = fir_x_q;
    fir_x_valid_d   = 1'b0;
    flush_pending_d = flush_pending_q | enable_fall_s;
    enable_d        = enable;
    discard_d       = discard_q;
    push_s          = 1'b0;
    push_data_s     = fir_y;
    case (state_q)
      S_IDLE: begin
        if (flush_pending_q) begin
          state_d         = S_FLUSH;
          flush_pending_d = enable_fall_s;
          cnt_d           = CW'(TAPS - 1);
          fir_x_d         = '0;
          fir_x_valid_d   = 1'b1;
        end else if (accept_s) begin
          if (bypass) begin
            push_s      = 1'b1;
            push_data_s = s_data;
          end else begin
            state_d       = S_ISSUE;
            fir_x_d       = s_data;
            fir_x_valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (FIR_LAT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(FIR_LAT - 1);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (fir_y_valid) begin
          push_s      = 1'b1;
          push_data_s = fir_y;
        end else if (discard_q != 8'hFF) begin
          discard_d = discard_q + 8'd1;
        end else begin
          discard_d = discard_q;
        end
      end
      S_FLUSH: begin
        fir_x_d = '0;
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(FIR_LAT - 1);
        end else begin
          cnt_d         = cnt_q - CW'(1);
          fir_x_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      fir_x_q         <= '0;
      fir_x_valid_q   <= 1'b0;
      flush_pending_q <= 1'b0;
      enable_q        <= 1'b0;
      discard_q       <= 8'd0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fir_x_q         <= fir_x_d;
      fir_x_valid_q   <= fir_x_valid_d;
      flush_pending_q <= flush_pending_d;
      enable_q        <= enable_d;
      discard_q       <= discard_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign s_ready     = s_ready_s;
  assign fir_x       = fir_x_q;
  assign fir_x_valid = fir_x_valid_q;
  assign m_data      = mem_q[rd_ptr_q];
  assign m_valid     = (count_q != '0);
  assign busy        = (state_q != S_IDLE);
  assign discard_cnt = discard_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a fake fixed-latency FIR plus a queue-based reference model
// of the stream behaviour, with directed and randomized traffic.
module tb_fir_stream_ctrl;
  localparam int DW = 16, TAPS = 32, FIR_LAT = 5, DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, bypass = 1'b0;
  logic s_valid = 1'b0, fir_y_valid = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, fir_x_valid, m_valid, busy;
  logic [DW-1:0] fir_x, fir_y, m_data;
  logic [7:0] discard_cnt;

  fir_stream_ctrl #(.DW(DW), .TAPS(TAPS), .FIR_LAT(FIR_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fir_x(fir_x), .fir_x_valid(fir_x_valid), .fir_y(fir_y), .fir_y_valid(fir_y_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, flush_strobes = 0, disc_events = 0, disc_base = 0;
  logic y_fixed_en = 1'b0, rnd_mready = 1'b0;
  logic [DW-1:0] y_fixed = '0;
  typedef struct { int c; logic [DW-1:0] d; } iss_t;
  iss_t issue_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pipe [FIR_LAT];

  function automatic logic [DW-1:0] filt(input logic [DW-1:0] x);
    return x * 16'd3 + 16'h1357;
  endfunction

  function automatic int disc_exp();
    int v;
    v = disc_events - disc_base;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fake FIR: result of a strobed sample appears exactly FIR_LAT cycles later; noise otherwise.
  always @(posedge clk) begin
    pipe[0] <= fir_x_valid ? filt(fir_x) : DW'($urandom);
    for (int k = 1; k < FIR_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign fir_y = y_fixed_en ? y_fixed : pipe[FIR_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: ordered expected outputs, issue timing, flush strobes, discards.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("m_unexpected", {31'b0, m_valid}, 32'd0);
        else chk("m_data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
      end
      if (s_valid && s_ready) begin
        if (bypass) exp_q.push_back(s_data);
        else begin
          issue_q.push_back('{cyc, s_data});
          if (fir_y_valid) exp_q.push_back(y_fixed_en ? y_fixed : filt(s_data));
          else disc_events <= disc_events + 1;
        end
      end
      if (fir_x_valid) begin
        if (issue_q.size() != 0) begin
          chk("issue_cycle", cyc, issue_q[0].c + 1);
          chk("issue_data", {16'b0, fir_x}, {16'b0, issue_q[0].d});
          void'(issue_q.pop_front());
        end else begin
          chk("flush_x_zero", {16'b0, fir_x}, 32'd0);
          flush_strobes <= flush_strobes + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_mready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic try_send(input logic [DW-1:0] d, input int budget, output bit ok);
    s_data = d; s_valid = 1'b1; ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      #1;
      if (s_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) tick();
    s_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    try_send(d, 40, ok);
    chk("send_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (m_valid && n < budget) begin tick(); n++; end
    chk("drain_mvalid", {31'b0, m_valid}, 32'd0);
    chk("drain_model_empty", exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_fxv"}, {31'b0, fir_x_valid}, 32'd0);
    chk({tag, "_fx"}, {16'b0, fir_x}, 32'd0);
    chk({tag, "_mvalid"}, {31'b0, m_valid}, 32'd0);
    chk({tag, "_mdata"}, {16'b0, m_data}, 32'd0);
    chk({tag, "_sready"}, {31'b0, s_ready}, 32'd0);
    chk({tag, "_disc"}, {24'b0, discard_cnt}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, fs0, nb, run, gap;
    bit broken, ok;

    // Reset state, with a sample already offered.
    enable = 1'b1; s_valid = 1'b1; s_data = 16'h1234; fir_y_valid = 1'b1;
    y_fixed_en = 1'b1; y_fixed = 16'h0ABC;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");

    // Filtered-path latency.
    reset = 1'b0; #1;
    chk("t1_sready_c0", {31'b0, s_ready}, 32'd1);
    tick(); s_valid = 1'b0;
    chk("t1_fxv_c1", {31'b0, fir_x_valid}, 32'd1);
    chk("t1_fx_c1", {16'b0, fir_x}, 32'h1234);
    for (int k = 1; k <= 6; k++) begin
      chk("t1_sready_low", {31'b0, s_ready}, 32'd0);
      chk("t1_mvalid_low", {31'b0, m_valid}, 32'd0);
      tick();
    end
    chk("t1_mvalid_c7", {31'b0, m_valid}, 32'd1);
    chk("t1_mdata_c7", {16'b0, m_data}, 32'h0ABC);
    chk("t1_sready_c7", {31'b0, s_ready}, 32'd1);
    m_ready = 1'b1; tick();
    chk("t1_popped", {31'b0, m_valid}, 32'd0);
    y_fixed_en = 1'b0;

    // Discards and saturation.
    fir_y_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin send(DW'($urandom)); wait_idle(20); end
    chk("disc_mvalid", {31'b0, m_valid}, 32'd0);
    chk("disc3", {24'b0, discard_cnt}, 32'd3);
    for (int i = 0; i < 300; i++) begin send(DW'($urandom)); wait_idle(20); end
    chk("disc_sat", {24'b0, discard_cnt}, 32'd255);
    chk("disc_model", {24'b0, discard_cnt}, disc_exp());

    // Back-pressure: FIFO fills at DEPTH, then drains in order.
    fir_y_valid = 1'b1; m_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(DW'($urandom), 12, ok);
      if (ok) acc++;
    end
    chk("full_accepts", acc, DEPTH);
    chk("full_sready", {31'b0, s_ready}, 32'd0);
    chk("full_mvalid", {31'b0, m_valid}, 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin send(DW'($urandom)); wait_idle(20); end
    drain(20);

    // Bypass back-to-back.
    bypass = 1'b1; fs0 = flush_strobes;
    for (int i = 1; i <= 5; i++) begin
      s_data = DW'(i); s_valid = 1'b1; #1;
      chk("byp_sready", {31'b0, s_ready}, 32'd1);
      if (i > 1) begin
        chk("byp_mvalid", {31'b0, m_valid}, 32'd1);
        chk("byp_mdata", {16'b0, m_data}, i - 1);
      end
      tick();
    end
    s_valid = 1'b0;
    chk("byp_mvalid5", {31'b0, m_valid}, 32'd1);
    chk("byp_mdata5", {16'b0, m_data}, 32'd5);
    tick();
    chk("byp_empty", {31'b0, m_valid}, 32'd0);
    chk("byp_no_strobe", flush_strobes - fs0, 32'd0);
    bypass = 1'b0;

    // Randomized mixed traffic.
    rnd_mready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle(20);
        fir_y_valid = 1'($urandom_range(0, 1));
      end
      bypass = 1'($urandom_range(0, 1));
      send(DW'($urandom));
    end
    rnd_mready = 1'b0; m_ready = 1'b1; bypass = 1'b0;
    wait_idle(20); drain(20);
    chk("rnd_disc", {24'b0, discard_cnt}, disc_exp());
    fir_y_valid = 1'b1;

    // Flush triggered during WAIT, enable re-raised mid-flush.
    fs0 = flush_strobes; acc = disc_exp();
    send(DW'($urandom)); tick(); tick();
    chk("fl_busy_wait", {31'b0, busy}, 32'd1);
    enable = 1'b0;
    nb = 0;
    while (!fir_x_valid && nb < 20) begin tick(); nb++; end
    chk("fl_start", {31'b0, fir_x_valid}, 32'd1);
    nb = 0; run = 0; gap = 0; broken = 1'b0;
    while (busy && nb < 60) begin
      nb++;
      if (fir_x_valid) begin
        if (broken) gap++; else run++;
      end else broken = 1'b1;
      if (nb == 10) enable = 1'b1;
      tick();
    end
    chk("fl_busy_len", nb, TAPS + FIR_LAT);
    chk("fl_run", run, TAPS);
    chk("fl_gap", gap, 32'd0);
    chk("fl_strobes", flush_strobes - fs0, TAPS);
    chk("fl_captured", exp_q.size(), 32'd0);
    chk("fl_no_push", {31'b0, m_valid}, 32'd0);
    chk("fl_disc", {24'b0, discard_cnt}, acc);
    chk("fl_resume", {31'b0, s_ready}, 32'd1);

    // Reset during WAIT with a result parked in the FIFO.
    m_ready = 1'b0;
    send(DW'($urandom)); wait_idle(20);
    send(DW'($urandom)); tick(); tick();
    reset = 1'b1; #1;
    chk_reset_outputs("rstw");
    exp_q.delete(); issue_q.delete(); disc_base = disc_events;
    tick(); reset = 1'b0; m_ready = 1'b1;
    send(DW'($urandom)); wait_idle(20); drain(20);

    // Reset during FLUSH.
    enable = 1'b0; nb = 0;
    while (!fir_x_valid && nb < 20) begin tick(); nb++; end
    tick(); tick(); tick();
    chk("rstf_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk_reset_outputs("rstf");
    issue_q.delete(); exp_q.delete(); disc_base = disc_events;
    tick(); reset = 1'b0; enable = 1'b1; tick(); tick();
    chk("rstf_idle", {31'b0, busy}, 32'd0);
    send(DW'($urandom)); wait_idle(20); drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
